// File: rtl/mc_controller_if.sv
// Memory handshake bundle between the multicycle controller and its memories.
interface mc_controller_if;
  logic       imem_req;
  logic       imem_ready;
  logic       dmem_req;
  logic       dmem_ready;
  logic [3:0] dm_w_en;

  modport master (
    output imem_req, dmem_req, dm_w_en,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, dm_w_en,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle RV32I controller: FETCH/DECODE/EXEC/MEM/WB with trap state.
// Optional MC_CTRL_TIMEOUT_EN bounds memory waits by TIMEOUT_CYC cycles.
module mc_controller #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  mc_controller_if.master  mem,
  input  logic [4:0]       opcode,
  input  logic [2:0]       func3,
  input  logic             func7,
  input  logic             BrEq,
  input  logic             BrLT,
  output logic             ir_we,
  output logic             pc_we,
  output logic             next_pc_sel,
  output logic             BrUn,
  output logic [3:0]       alu_op,
  output logic             alu_op1_sel,
  output logic             alu_op2_sel,
  output logic             wb_en,
  output logic [1:0]       wb_sel,
  output logic             isLui,
  output logic [2:0]       state,
  output logic             trap,
  output logic             retired,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_LUI    = 5'b01101;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       op1_pc;
    logic       op2_imm;
    logic [1:0] wb_sel;
    logic       br_un;
    logic       is_lui;
  } ctl_t;

  typedef struct packed {
    logic       ld;
    logic       st;
    logic       br;
    logic       jmp;
    logic [2:0] f3;
  } cls_t;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t           state_q;
  ctl_t             ctl_d;
  ctl_t             ctl_q;
  ctl_t             ctl;
  cls_t             cls_d;
  cls_t             cls_q;
  logic             illegal;
  logic             take;
  logic             to_hit;
  logic [3:0]       st_mask;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    ctl_d   = '0;
    cls_d   = '0;
    cls_d.f3 = func3;
    illegal = 1'b0;
    unique case (1'b1)
      opcode == OPC_LOAD: begin
        cls_d.ld       = 1'b1;
        ctl_d.op2_imm  = 1'b1;
        ctl_d.wb_sel   = 2'd1;
      end
      opcode == OPC_STORE: begin
        cls_d.st       = 1'b1;
        ctl_d.op2_imm  = 1'b1;
        illegal = func3[2] | (func3[1:0] == 2'b11);
      end
      opcode == OPC_BRANCH: begin
        cls_d.br       = 1'b1;
        ctl_d.op1_pc   = 1'b1;
        ctl_d.op2_imm  = 1'b1;
        ctl_d.br_un    = func3[1];
        illegal = (func3[2:1] == 2'b01);
      end
      opcode == OPC_JALR: begin
        cls_d.jmp      = 1'b1;
        ctl_d.op2_imm  = 1'b1;
        ctl_d.wb_sel   = 2'd2;
      end
      opcode == OPC_JAL: begin
        cls_d.jmp      = 1'b1;
        ctl_d.op1_pc   = 1'b1;
        ctl_d.op2_imm  = 1'b1;
        ctl_d.wb_sel   = 2'd2;
      end
      opcode == OPC_OP_IMM: begin
        ctl_d.op2_imm  = 1'b1;
        ctl_d.alu_op   = {func7 & (func3 == 3'b101), func3};
      end
      opcode == OPC_OP: begin
        ctl_d.alu_op   = {func7 & (func3 == 3'b000 || func3 == 3'b101), func3};
      end
      opcode == OPC_AUIPC: begin
        ctl_d.op1_pc   = 1'b1;
        ctl_d.op2_imm  = 1'b1;
      end
      opcode == OPC_LUI: begin
        ctl_d.op2_imm  = 1'b1;
        ctl_d.is_lui   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // f3[0] inverts the sense: NE/GE/GEU are the negations of EQ/LT/LTU
  assign take = cls_q.f3[2] ? (BrLT ^ cls_q.f3[0]) : (BrEq ^ cls_q.f3[0]);

  always_comb begin
    case (cls_q.f3[1:0])
      2'b00:   st_mask = 4'b0001;
      2'b01:   st_mask = 4'b0011;
      default: st_mask = 4'b1111;
    endcase
  end

  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dm_w_en  = 4'b0000;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    next_pc_sel  = 1'b0;
    wb_en        = 1'b0;
    trap         = 1'b0;
    ctl          = '0;
    if (!rst) begin
      unique case (state_q)
        FETCH: begin
          mem.imem_req = 1'b1;
          ir_we        = mem.imem_ready;
        end
        DECODE: ctl = ctl_d;
        EXEC: begin
          ctl = ctl_q;
          if (cls_q.br) begin
            pc_we       = 1'b1;
            next_pc_sel = take;
          end
        end
        MEM: begin
          ctl          = ctl_q;
          mem.dmem_req = 1'b1;
          if (cls_q.st) mem.dm_w_en = st_mask;
          pc_we = cls_q.st & mem.dmem_ready;
        end
        WB: begin
          ctl         = ctl_q;
          wb_en       = 1'b1;
          pc_we       = 1'b1;
          next_pc_sel = cls_q.jmp;
        end
        TRAP: trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign alu_op      = ctl.alu_op;
  assign alu_op1_sel = ctl.op1_pc;
  assign alu_op2_sel = ctl.op2_imm;
  assign wb_sel      = ctl.wb_sel;
  assign BrUn        = ctl.br_un;
  assign isLui       = ctl.is_lui;
  assign retired     = pc_we;
  assign state       = rst ? 3'd0 : state_q;
  assign retire_cnt  = rst ? '0 : cnt_q;

`ifdef MC_CTRL_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_q;
  logic              waiting;

  // any ready-high cycle leaves FETCH/MEM, so clearing here tracks state changes
  assign waiting = (state_q == FETCH && !mem.imem_ready) ||
                   (state_q == MEM && !mem.dmem_ready);
  assign to_hit  = waiting && (wait_q == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || !waiting) wait_q <= '0;
    else                 wait_q <= wait_q + WAIT_W'(1);
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      ctl_q   <= '0;
      cls_q   <= '0;
    end else begin
      if (pc_we) cnt_q <= cnt_q + CNT_W'(1);
      unique case (state_q)
        FETCH: begin
          if (mem.imem_ready) state_q <= DECODE;
          else if (to_hit)    state_q <= TRAP;
        end
        DECODE: begin
          ctl_q   <= ctl_d;
          cls_q   <= cls_d;
          state_q <= illegal ? TRAP : EXEC;
        end
        EXEC: begin
          if (cls_q.ld || cls_q.st) state_q <= MEM;
          else if (cls_q.br)        state_q <= FETCH;
          else                      state_q <= WB;
        end
        MEM: begin
          if (mem.dmem_ready) state_q <= cls_q.st ? FETCH : WB;
          else if (to_hit)    state_q <= TRAP;
        end
        WB:      state_q <= FETCH;
        TRAP:    state_q <= TRAP;
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-instruction traces, strobes, reset, trap.
module tb_mc_controller;

  localparam logic [4:0] L_LOAD   = 5'b00000;
  localparam logic [4:0] L_STORE  = 5'b01000;
  localparam logic [4:0] L_BRANCH = 5'b11000;
  localparam logic [4:0] L_JALR   = 5'b11001;
  localparam logic [4:0] L_JAL    = 5'b11011;
  localparam logic [4:0] L_OPI    = 5'b00100;
  localparam logic [4:0] L_OP     = 5'b01100;
  localparam logic [4:0] L_AUIPC  = 5'b00101;
  localparam logic [4:0] L_LUI    = 5'b01101;

  typedef struct {
    logic [63:0] trace;
    int          lat;
    logic        npc;
    logic        wb;
    logic [3:0]  dm;
    logic [9:0]  ctl;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [4:0] opcode;
  logic [2:0] func3;
  logic       func7;
  logic       BrEq;
  logic       BrLT;
  logic       ir_we;
  logic       pc_we;
  logic       next_pc_sel;
  logic       BrUn;
  logic [3:0] alu_op;
  logic       alu_op1_sel;
  logic       alu_op2_sel;
  logic       wb_en;
  logic [1:0] wb_sel;
  logic       isLui;
  logic [2:0] state;
  logic       trap;
  logic       retired;
  logic [3:0] retire_cnt;

  mc_controller_if mif ();

  mc_controller #(
    .CNT_W       (4),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem         (mif),
    .opcode      (opcode),
    .func3       (func3),
    .func7       (func7),
    .BrEq        (BrEq),
    .BrLT        (BrLT),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .next_pc_sel (next_pc_sel),
    .BrUn        (BrUn),
    .alu_op      (alu_op),
    .alu_op1_sel (alu_op1_sel),
    .alu_op2_sel (alu_op2_sel),
    .wb_en       (wb_en),
    .wb_sel      (wb_sel),
    .isLui       (isLui),
    .state       (state),
    .trap        (trap),
    .retired     (retired),
    .retire_cnt  (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] model_cnt;
  exp_t       sb[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_alu(input logic [4:0] op,
                                       input logic [2:0] f3,
                                       input logic f7);
    if (op != L_OP && op != L_OPI) return 4'd0;
    case (f3)
      3'd0:    return (op == L_OP && f7) ? 4'd8 : 4'd0;
      3'd1:    return 4'd1;
      3'd2:    return 4'd2;
      3'd3:    return 4'd3;
      3'd4:    return 4'd4;
      3'd5:    return f7 ? 4'd13 : 4'd5;
      3'd6:    return 4'd6;
      default: return 4'd7;
    endcase
  endfunction

  function automatic logic m_take(input logic [2:0] f3, input logic eq,
                                  input logic lt);
    case (f3)
      3'd0:    return eq;
      3'd1:    return !eq;
      3'd4:    return lt;
      3'd5:    return !lt;
      3'd6:    return lt;
      default: return !lt;
    endcase
  endfunction

  task automatic run_instr(input logic [4:0] op, input logic [2:0] f3,
                           input logic f7, input logic eq, input logic lt,
                           input int iw, input int dw, input logic noise);
    exp_t        e;
    exp_t        g;
    logic        is_ld, is_st, is_br, is_j;
    logic [1:0]  wsel;
    logic [63:0] tr;
    logic [3:0]  code;
    logic [3:0]  dms;
    logic        wbs, dmbad, done;
    int          fw, mw, cyc, irs;
    is_ld = (op == L_LOAD);
    is_st = (op == L_STORE);
    is_br = (op == L_BRANCH);
    is_j  = (op == L_JAL) || (op == L_JALR);
    e.lat = (is_br ? 3 : is_ld ? 5 : 4) + iw + ((is_ld || is_st) ? dw : 0);
    e.trace = '0;
    for (int i = 0; i <= iw; i++) e.trace = {e.trace[59:0], 4'd1};
    e.trace = {e.trace[59:0], 4'd2};
    e.trace = {e.trace[59:0], 4'd3};
    if (is_ld || is_st)
      for (int i = 0; i <= dw; i++) e.trace = {e.trace[59:0], 4'd4};
    if (!is_br && !is_st) e.trace = {e.trace[59:0], 4'd5};
    e.npc = is_br ? m_take(f3, eq, lt) : is_j;
    e.wb  = !(is_br || is_st);
    e.dm  = !is_st ? 4'd0 : (f3 == 3'd0) ? 4'b0001 :
            (f3 == 3'd1) ? 4'b0011 : 4'b1111;
    wsel  = is_ld ? 2'd1 : is_j ? 2'd2 : 2'd0;
    e.ctl = {m_alu(op, f3, f7),
             op == L_BRANCH || op == L_JAL || op == L_AUIPC,
             op != L_OP, wsel,
             is_br && (f3 == 3'd6 || f3 == 3'd7),
             op == L_LUI};
    sb.push_back(e);
    opcode = op; func3 = f3; func7 = f7; BrEq = eq; BrLT = lt;
    fw = 0; mw = 0; cyc = 0; irs = 0;
    tr = '0; dms = '0; wbs = 0; dmbad = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (state == 3'd0) begin
        mif.imem_ready = (fw == iw);
        fw++;
      end else mif.imem_ready = noise;
      if (state == 3'd3) begin
        mif.dmem_ready = (mw == dw);
        mw++;
      end else mif.dmem_ready = noise;
      #1;
      cyc++;
      code = {1'b0, state} + 4'd1;
      tr = {tr[59:0], code};
      if (wb_en) wbs = 1'b1;
      if (ir_we) irs++;
      if (mif.dm_w_en != 4'd0) begin
        dms = mif.dm_w_en;
        if (!mif.dmem_req) dmbad = 1'b1;
      end
      if (retired) begin
        done = 1'b1;
        g = sb.pop_front();
        chk("latency", 64'(cyc), 64'(g.lat));
        chk("state_trace", tr, g.trace);
        chk("pc_we", {63'd0, pc_we}, 64'd1);
        chk("next_pc_sel", {63'd0, next_pc_sel}, {63'd0, g.npc});
        chk("wb_en_seen", {63'd0, wbs}, {63'd0, g.wb});
        chk("dm_w_en", {60'd0, dms}, {60'd0, g.dm});
        chk("dm_w_en_gated", {63'd0, dmbad}, 64'd0);
        chk("ir_we_count", 64'(irs), 64'd1);
        chk("ctl", {54'd0, alu_op, alu_op1_sel, alu_op2_sel, wb_sel,
                    BrUn, isLui}, {54'd0, g.ctl});
        model_cnt = model_cnt + 4'd1;
      end
    end
    if (!done) chk("retire_timeout", 64'd0, 64'd1);
    @(negedge clk);
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    #1;
    chk("retire_cnt", {60'd0, retire_cnt}, {60'd0, model_cnt});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_cnt = '0;
  endtask

  initial begin
    logic bad;
    logic hit;
    int   n;
    rst = 1'b1;
    opcode = L_OP; func3 = 3'd0; func7 = 1'b0; BrEq = 1'b0; BrLT = 1'b0;
    mif.imem_ready = 1'b1;
    mif.dmem_ready = 1'b1;
    model_cnt = '0;
    @(negedge clk);
    #1;
    chk("rst_state", {61'd0, state}, 64'd0);
    chk("rst_imem_req", {63'd0, mif.imem_req}, 64'd0);
    chk("rst_ir_we", {63'd0, ir_we}, 64'd0);
    chk("rst_trap", {63'd0, trap}, 64'd0);
    chk("rst_retire_cnt", {60'd0, retire_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    #1;
    chk("post_rst_imem_req", {63'd0, mif.imem_req}, 64'd1);

    run_instr(L_OP,     3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(L_LOAD,   3'd2, 1'b0, 1'b0, 1'b0, 0, 3, 1'b0);
    run_instr(L_STORE,  3'd1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(L_BRANCH, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(L_BRANCH, 3'd7, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(L_OP,     3'd0, 1'b1, 1'b0, 1'b0, 1, 0, 1'b1);
    run_instr(L_OP,     3'd5, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(L_OPI,    3'd5, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    run_instr(L_OPI,    3'd0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(L_OP,     3'd3, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(L_JAL,    3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    run_instr(L_JALR,   3'd0, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0);
    run_instr(L_LUI,    3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(L_AUIPC,  3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    run_instr(L_STORE,  3'd2, 1'b0, 1'b0, 1'b0, 2, 1, 1'b1);
    run_instr(L_STORE,  3'd0, 1'b0, 1'b0, 1'b0, 0, 2, 1'b1);
    run_instr(L_BRANCH, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    run_instr(L_BRANCH, 3'd4, 1'b0, 1'b1, 1'b1, 2, 0, 1'b0);
    run_instr(L_BRANCH, 3'd6, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    run_instr(L_LOAD,   3'd4, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

    // illegal opcode: trap sticks, nothing else moves, rst recovers
    opcode = 5'b11111;
    @(negedge clk);
    mif.imem_ready = (state == 3'd0);
    @(negedge clk);
    mif.imem_ready = 1'b1;
    mif.dmem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("trap_state", {61'd0, state}, 64'd5);
    chk("trap_flag", {63'd0, trap}, 64'd1);
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (mif.imem_req || mif.dmem_req || ir_we || pc_we || wb_en)
        bad = 1'b1;
    end
    chk("trap_quiet", {63'd0, bad}, 64'd0);
    chk("trap_held", {63'd0, trap}, 64'd1);
    chk("trap_retire_cnt", {60'd0, retire_cnt}, {60'd0, model_cnt});
    rst = 1'b1;
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    #1;
    chk("trap_rst_flag", {63'd0, trap}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_cnt = '0;
    #1;
    chk("trap_rst_cnt", {60'd0, retire_cnt}, 64'd0);
    chk("trap_rst_state", {61'd0, state}, 64'd0);
    chk("trap_rst_imem_req", {63'd0, mif.imem_req}, 64'd1);

    // reset while a store is waiting in MEM
    run_instr(L_OP, 3'd7, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    opcode = L_STORE;
    func3  = 3'd2;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (state == 3'd3) hit = 1'b1;
      else mif.imem_ready = (state == 3'd0);
    end
    chk("mid_reach_mem", {63'd0, hit}, 64'd1);
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_pc_we", {63'd0, pc_we}, 64'd0);
    chk("mid_dm_w_en", {60'd0, mif.dm_w_en}, 64'd0);
    chk("mid_dmem_req", {63'd0, mif.dmem_req}, 64'd0);
    chk("mid_retired", {63'd0, retired}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mif.dmem_ready = 1'b0;
    model_cnt = '0;
    #1;
    chk("mid_after_state", {61'd0, state}, 64'd0);
    chk("mid_after_cnt", {60'd0, retire_cnt}, 64'd0);

    // 4-bit counter wraps after 16 retirements
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) run_instr(L_OPI, 3'd6, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      else run_instr(L_BRANCH, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    end
    chk("cnt_wrap", {60'd0, retire_cnt}, 64'd0);

`ifdef MC_CTRL_TIMEOUT_EN
    rst = 1'b1;
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (state != 3'd0) break;
      n++;
      @(negedge clk);
      #1;
    end
    chk("to_fetch_cycles", 64'(n), 64'd4);
    chk("to_trap", {63'd0, trap}, 64'd1);
    do_reset();
`else
    n = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timed out");
  end

endmodule
